// File: rtl/pmem_arbiter_if.sv
// Bundle of the split-L1 cache ports, the physical-memory line port and the
// grant counters. The arbiter uses the slave view; the caches and memory use master.
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
);
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;
  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  logic [CNT_WIDTH-1:0]  i_grant_count;
  logic [CNT_WIDTH-1:0]  d_grant_count;

  modport slave (
    input  i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write,
           d_pmem_address, d_pmem_wdata, pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata,
           i_grant_count, d_grant_count
  );

  modport master (
    output i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write,
           d_pmem_address, d_pmem_wdata, pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata,
           i_grant_count, d_grant_count
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port between the I- and
// D-cache engines, with a one-cycle release gap and saturating grant counters.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input logic          clk,
  input logic          reset_n,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state, state_nxt;
  logic                  last_d;
  logic                  grant_i, grant_d;
  logic                  i_req, d_req;
  logic                  done;
  logic                  read_q, write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [CNT_WIDTH-1:0]  i_cnt, d_cnt;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;
  assign done  = ((state == SERVE_I) || (state == SERVE_D)) && bus.pmem_resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || !last_d)) begin
          grant_d   = 1'b1;
          state_nxt = SERVE_D;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_nxt = SERVE_I;
        end
      end
      SERVE_I: if (bus.pmem_resp) state_nxt = RELEASE;
      SERVE_D: if (bus.pmem_resp) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_d  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      i_cnt   <= '0;
      d_cnt   <= '0;
    end else begin
      if (grant_d) begin
        addr_q  <= bus.d_pmem_address;
        wdata_q <= bus.d_pmem_wdata;
        write_q <= bus.d_pmem_write;
        read_q  <= bus.d_pmem_read & ~bus.d_pmem_write;
        last_d  <= 1'b1;
      end
      if (grant_i) begin
        addr_q  <= bus.i_pmem_address;
        read_q  <= 1'b1;
        write_q <= 1'b0;
        last_d  <= 1'b0;
      end
      if (done) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
        if (state == SERVE_I && i_cnt != '1) i_cnt <= i_cnt + CNT_ONE;
        if (state == SERVE_D && d_cnt != '1) d_cnt <= d_cnt + CNT_ONE;
      end
    end
  end

  assign bus.pmem_read     = read_q;
  assign bus.pmem_write    = write_q;
  assign bus.pmem_address  = addr_q;
  assign bus.pmem_wdata    = wdata_q;
  assign bus.i_pmem_rdata  = (state == SERVE_I) ? bus.pmem_rdata : '0;
  assign bus.d_pmem_rdata  = (state == SERVE_D) ? bus.pmem_rdata : '0;
  assign bus.i_pmem_resp   = (state == SERVE_I) && bus.pmem_resp;
  assign bus.d_pmem_resp   = (state == SERVE_D) && bus.pmem_resp;
  assign bus.i_grant_count = i_cnt;
  assign bus.d_grant_count = d_cnt;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: behavioural cache/memory agents, a transaction-level
// reference model, a directed vector table and multi-cycle corner sequences.
module tb_pmem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam int CW = 5;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) bus ();
  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [AW-1:0] addr;
    logic rd, wr;
    logic [LW-1:0] wdata;
  } dreq_t;

  typedef struct {
    bit i_en; logic [AW-1:0] i_addr;
    bit d_en; logic d_rd, d_wr; logic [AW-1:0] d_addr; logic [LW-1:0] d_wdata;
    logic exp_rd, exp_wr; logic [AW-1:0] exp_addr; logic [LW-1:0] exp_wdata;
    bit exp_first_d; int unsigned exp_icnt, exp_dcnt;
  } vec_t;

  int unsigned vectors = 0, miscompares = 0, cyc = 0;

  // reference model: one owner at a time, a blocked cycle after each completion
  bit m_busy, m_owner_d, m_release, m_last_d;
  logic m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  int unsigned m_icnt, m_dcnt;

  // agents
  logic [AW-1:0] iq[$];
  dreq_t dq[$];
  bit i_hold, d_hold, i_got, d_got, i_wd, d_scr, lat_rand;
  int unsigned i_age, d_age, mem_cnt, mem_lat, spur_pct;
  bit mem_fixed;
  logic [LW-1:0] mem_val, i_last_rdata;
  bit resp_order[$];
  int unsigned resp_cyc[$], rise_cyc[$], i_resp_seen;
  bit prev_strobe;

  function automatic void chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner_d = 0; m_release = 0; m_last_d = 0;
    m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0; m_icnt = 0; m_dcnt = 0;
  endtask

  task automatic model_step();
    bit ir, dr, pick_d;
    if (!reset_n) begin
      model_reset();
    end else if (m_busy) begin
      if (bus.pmem_resp) begin
        m_busy = 0; m_release = 1; m_rd = 0; m_wr = 0;
        if (m_owner_d) m_dcnt = (m_dcnt < CMAX) ? m_dcnt + 1 : CMAX;
        else           m_icnt = (m_icnt < CMAX) ? m_icnt + 1 : CMAX;
      end
    end else if (m_release) begin
      m_release = 0;
    end else begin
      ir = bus.i_pmem_read;
      dr = bus.d_pmem_read | bus.d_pmem_write;
      if (ir || dr) begin
        pick_d = dr && !(ir && m_last_d);
        m_busy = 1; m_owner_d = pick_d; m_last_d = pick_d;
        if (pick_d) begin
          m_addr = bus.d_pmem_address; m_wdata = bus.d_pmem_wdata;
          m_wr = bus.d_pmem_write; m_rd = bus.d_pmem_read && !bus.d_pmem_write;
        end else begin
          m_addr = bus.i_pmem_address; m_rd = 1; m_wr = 0;
        end
      end
    end
  endtask

  task automatic agents_clear();
    iq.delete(); dq.delete();
    i_hold = 0; d_hold = 0; i_got = 0; d_got = 0; mem_cnt = 0; prev_strobe = 0;
    bus.i_pmem_read = 0; bus.i_pmem_address = '0;
    bus.d_pmem_read = 0; bus.d_pmem_write = 0; bus.d_pmem_address = '0;
    bus.d_pmem_wdata = '0; bus.pmem_resp = 0; bus.pmem_rdata = '0;
    resp_order.delete(); resp_cyc.delete(); rise_cyc.delete(); i_resp_seen = 0;
  endtask

  task automatic drive_agents();
    dreq_t r;
    if (i_hold) begin
      i_age++;
      if (i_got) begin bus.i_pmem_read = 0; i_hold = 0; end
      else if (i_wd && i_age == 3) bus.i_pmem_read = 0;
    end else if (iq.size() > 0) begin
      bus.i_pmem_read = 1; bus.i_pmem_address = iq.pop_front(); i_hold = 1; i_age = 0;
    end
    if (d_hold) begin
      d_age++;
      if (d_got) begin
        bus.d_pmem_read = 0; bus.d_pmem_write = 0; d_hold = 0;
      end else if (d_scr) begin
        bus.d_pmem_wdata = rnd_line(); bus.d_pmem_address = AW'($urandom);
      end
    end else if (dq.size() > 0) begin
      r = dq.pop_front();
      bus.d_pmem_read = r.rd; bus.d_pmem_write = r.wr;
      bus.d_pmem_address = r.addr; bus.d_pmem_wdata = r.wdata; d_hold = 1; d_age = 0;
    end
    bus.pmem_rdata = mem_fixed ? mem_val : rnd_line();
    if (bus.pmem_read || bus.pmem_write) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        bus.pmem_resp = 1; mem_cnt = 0;
        if (lat_rand) mem_lat = $urandom_range(1, 6);
      end else bus.pmem_resp = 0;
    end else begin
      mem_cnt = 0;
      bus.pmem_resp = ($urandom_range(0, 99) < spur_pct);
    end
  endtask

  task automatic check_all();
    bit own_i, own_d;
    own_i = m_busy && !m_owner_d;
    own_d = m_busy && m_owner_d;
    chk("pmem_read", bus.pmem_read, m_rd);
    chk("pmem_write", bus.pmem_write, m_wr);
    chk("pmem_address", bus.pmem_address, m_addr);
    chk("pmem_wdata", bus.pmem_wdata, m_wdata);
    chk("i_resp", bus.i_pmem_resp, own_i && bus.pmem_resp);
    chk("d_resp", bus.d_pmem_resp, own_d && bus.pmem_resp);
    chk("i_rdata", bus.i_pmem_rdata, own_i ? bus.pmem_rdata : '0);
    chk("d_rdata", bus.d_pmem_rdata, own_d ? bus.pmem_rdata : '0);
    chk("i_count", bus.i_grant_count, m_icnt);
    chk("d_count", bus.d_grant_count, m_dcnt);
  endtask

  task automatic tick();
    bit strobe;
    @(posedge clk); model_step(); cyc++;
    @(negedge clk); drive_agents(); #1;
    check_all();
    i_got = bus.i_pmem_resp; d_got = bus.d_pmem_resp;
    if (i_got) begin resp_order.push_back(0); resp_cyc.push_back(cyc); i_last_rdata = bus.i_pmem_rdata; i_resp_seen++; end
    if (d_got) begin resp_order.push_back(1); resp_cyc.push_back(cyc); end
    strobe = bus.pmem_read | bus.pmem_write;
    if (strobe && !prev_strobe) rise_cyc.push_back(cyc);
    prev_strobe = strobe;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; agents_clear(); model_reset();
    @(negedge clk); @(negedge clk);
    reset_n = 1;
  endtask

  task automatic drain(int unsigned bound);
    bit idle;
    idle = 0;
    for (int unsigned n = 0; n < bound && !idle; n++) begin
      tick();
      idle = (iq.size() == 0) && (dq.size() == 0) && !i_hold && !d_hold;
    end
    chk("drain_done", idle, 1'b1);
    tick(); tick();
  endtask

  vec_t vecs[5];
  localparam logic [LW-1:0] W1 = {8{16'h1357}};
  localparam logic [LW-1:0] W2 = {8{16'h2468}};
  localparam logic [LW-1:0] W5 = {8{16'h5555}};
  localparam logic [LW-1:0] WA = {8{16'hAAAA}};

  initial begin
    dreq_t r;
    bit exp_alt[4];
    reset_n = 0; agents_clear(); model_reset();
    mem_lat = 3; lat_rand = 0; spur_pct = 0; i_wd = 0; d_scr = 1; mem_fixed = 1; mem_val = WA;

    vecs[0] = '{1, 16'h1230, 0, 0, 0, 16'h0,    '0, 1, 0, 16'h1230, '0, 0, 1, 0};
    vecs[1] = '{0, 16'h0,    1, 1, 0, 16'h2000, W1, 1, 0, 16'h2000, W1, 1, 0, 1};
    vecs[2] = '{0, 16'h0,    1, 0, 1, 16'h4000, W5, 0, 1, 16'h4000, W5, 1, 0, 1};
    vecs[3] = '{0, 16'h0,    1, 1, 1, 16'h4100, W2, 0, 1, 16'h4100, W2, 1, 0, 1};
    vecs[4] = '{1, 16'h1230, 1, 1, 0, 16'h3000, W1, 1, 0, 16'h3000, W1, 1, 1, 1};

    do_reset();
    #1;
    chk("reset_read", bus.pmem_read, 1'b0);
    chk("reset_address", bus.pmem_address, '0);
    chk("reset_icount", bus.i_grant_count, '0);

    for (int unsigned v = 0; v < 5; v++) begin
      do_reset();
      if (vecs[v].i_en) iq.push_back(vecs[v].i_addr);
      if (vecs[v].d_en) begin
        r.addr = vecs[v].d_addr; r.rd = vecs[v].d_rd; r.wr = vecs[v].d_wr; r.wdata = vecs[v].d_wdata;
        dq.push_back(r);
      end
      tick(); tick();
      chk("vec_read", bus.pmem_read, vecs[v].exp_rd);
      chk("vec_write", bus.pmem_write, vecs[v].exp_wr);
      chk("vec_address", bus.pmem_address, vecs[v].exp_addr);
      drain(200);
      chk("vec_wdata_held", bus.pmem_wdata, vecs[v].exp_wdata);
      chk("vec_first_d", (resp_order.size() > 0) ? resp_order[0] : 1'bx, vecs[v].exp_first_d);
      chk("vec_icount", bus.i_grant_count, vecs[v].exp_icnt);
      chk("vec_dcount", bus.d_grant_count, vecs[v].exp_dcnt);
      if (vecs[v].i_en) chk("vec_i_rdata", i_last_rdata, WA);
    end
    mem_fixed = 0;

    // both requesters kept busy: D,I,D,I with a 3-cycle resp-to-strobe gap
    do_reset();
    exp_alt = '{1, 0, 1, 0};
    for (int unsigned k = 0; k < 2; k++) begin
      iq.push_back(AW'(16'h0100 + k));
      r.addr = AW'(16'h0200 + k); r.rd = 1; r.wr = 0; r.wdata = rnd_line(); dq.push_back(r);
    end
    drain(300);
    chk("alt_count", resp_order.size(), 4);
    if (resp_order.size() == 4 && rise_cyc.size() == 4)
      for (int unsigned k = 0; k < 4; k++) begin
        chk("alt_owner", resp_order[k], exp_alt[k]);
        if (k < 3) chk("alt_gap", rise_cyc[k+1] - resp_cyc[k], 3);
      end

    // request withdrawn mid-serve still completes
    do_reset();
    i_wd = 1; mem_lat = 5; iq.push_back(16'h0abc);
    drain(100);
    chk("withdraw_resp", i_resp_seen, 1);
    i_wd = 0;

    // async reset mid-transaction, then a tie goes to D
    do_reset();
    mem_lat = 10; iq.push_back(16'h1111);
    tick(); tick(); tick();
    chk("pre_reset_read", bus.pmem_read, 1'b1);
    #2; reset_n = 0; #1;
    chk("async_read_drop", bus.pmem_read, 1'b0);
    agents_clear(); model_reset();
    tick(); tick();
    reset_n = 1; mem_lat = 3;
    iq.push_back(16'h7000);
    r.addr = 16'h7100; r.rd = 1; r.wr = 0; r.wdata = rnd_line(); dq.push_back(r);
    tick(); tick();
    chk("post_reset_grant", bus.pmem_address, 16'h7100);
    drain(200);

    // spurious memory responses while idle
    do_reset();
    spur_pct = 100;
    for (int unsigned k = 0; k < 8; k++) tick();
    chk("spur_icount", bus.i_grant_count, '0);
    chk("spur_dcount", bus.d_grant_count, '0);
    spur_pct = 0;

    // counter saturation
    do_reset();
    mem_lat = 1;
    for (int unsigned k = 0; k < CMAX + 2; k++) iq.push_back(AW'(k));
    drain(2000);
    chk("sat_icount", bus.i_grant_count, CMAX);

    // randomized traffic
    do_reset();
    lat_rand = 1; spur_pct = 20;
    for (int unsigned it = 0; it < 400; it++) begin
      if (iq.size() < 2 && $urandom_range(0, 2) == 0) iq.push_back(AW'($urandom));
      if (dq.size() < 2 && $urandom_range(0, 2) == 0) begin
        r.addr = AW'($urandom); r.rd = 1'($urandom); r.wr = 1'($urandom);
        if (!r.rd && !r.wr) r.rd = 1;
        r.wdata = rnd_line(); dq.push_back(r);
      end
      for (int unsigned c = 0; c < $urandom_range(1, 4); c++) tick();
    end
    drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
